// File: rtl/register_file_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_dumper
//  Purpose  : Reader-side companion to the RegisterFile. Walks the registers
//             selected by a mask (R1..R4 = index 0..3, S1..S4 = index 4..7)
//             through the RF OutA read port and streams each value out over a
//             Valid/Ready handshake.
//  Ports    : clk_i        system clock, rising edge
//             rst_ni       asynchronous active-low reset
//             start_i      one-cycle dump request (honoured only when idle)
//             mask_i       register selection, sampled with the accepted start
//             out_a_i      RF read port A data
//             out_a_sel_o  RF read port A select
//             reg_sel_o    RF write enables R1..R4 (active-low)
//             scr_sel_o    RF write enables S1..S4 (active-low)
//             data_o       stream word (registered)
//             index_o      register index of data_o
//             valid_o      data_o/index_o/last_o valid
//             ready_i      consumer accept
//             last_o       final word of the dump
//             busy_o       dump in progress
//             done_o       one-cycle completion pulse
//  Config   : DUMP_CHECKSUM_EN - when defined, an extra word carrying the XOR
//             of all dumped words (index all-ones) closes every dump.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_dumper #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8,
  localparam int IDX_W = $clog2(N_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [N_REGS-1:0] mask_i,
  input  logic [DATA_W-1:0] out_a_i,
  output logic [IDX_W-1:0]  out_a_sel_o,
  output logic [3:0]        reg_sel_o,
  output logic [3:0]        scr_sel_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  index_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SEND   = 3'd2,
    S_CSUM   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              state_q,   state_d;
  logic [N_REGS-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]    sel_q,     sel_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic [IDX_W-1:0]    index_q,   index_d;
  logic                valid_q,   valid_d;
  logic                last_q,    last_d;
  logic [DATA_W-1:0]   csum_q,    csum_d;

  // Lowest set bit wins, so registers stream out in ascending index order.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REGS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    data_d    = data_q;
    index_d   = index_q;
    valid_d   = valid_q;
    last_d    = last_q;
    csum_d    = csum_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          csum_d = '0;
          if (|mask_i) begin
            pending_d = mask_i;
            state_d   = S_SELECT;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // An empty mask still emits the (zero) checksum word.
            state_d = S_CSUM;
`else
            state_d = S_FINISH;
`endif
          end
        end
      end

      S_SELECT: begin
        // The RF read is combinational and out_a_sel_o has been stable for
        // this whole cycle, so out_a_i is settled at this edge.
        data_d    = out_a_i;
        index_d   = sel_q;
        pending_d = pending_q & ~(N_REGS'(1) << sel_q);
        csum_d    = csum_q ^ out_a_i;
        valid_d   = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        last_d    = 1'b0;
`else
        last_d    = (pending_d == '0);
`endif
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_FINISH;
          end else if (pending_q == '0) begin
            // Only reachable with the checksum word enabled.
            state_d = S_CSUM;
          end else begin
            state_d = S_SELECT;
          end
        end
      end

      S_CSUM: begin
        data_d  = csum_q;
        index_d = '1;
        valid_d = 1'b1;
        last_d  = 1'b1;
        state_d = S_SEND;
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Select is registered ahead of SELECT so the RF has a full cycle to
    // settle; outside SELECT it simply holds.
    if (state_d == S_SELECT) begin
      sel_d = lowest_set(pending_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      csum_q    <= csum_d;
    end
  end

  // The dumper never writes the RF, so its write enables stay inactive; this
  // keeps the RF contents frozen for the whole dump.
  assign reg_sel_o   = 4'b1111;
  assign scr_sel_o   = 4'b1111;

  assign out_a_sel_o = sel_q;
  assign data_o      = data_q;
  assign index_o     = index_q;
  assign valid_o     = valid_q;
  assign last_o      = last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_register_file_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_dumper
//  Purpose  : Self-checking bench for register_file_dumper. An RF model feeds
//             OutA; expected words are queued per dump and a monitor compares
//             every accepted word against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_dumper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mask;
  logic [15:0] out_a;
  logic [2:0]  out_a_sel;
  logic [3:0]  reg_sel;
  logic [3:0]  scr_sel;
  logic [15:0] data;
  logic [2:0]  index;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [15:0] rf [8];
  int          checks = 0;
  int          errors = 0;
  int          words_seen = 0;
  int          done_cnt = 0;
  int          stall_base = 0;
  int          ready_mode = 0;   // 0 high, 1 random, 2 stall word 3, 3 low

  register_file_dumper #(.DATA_W(16), .N_REGS(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mask_i     (mask),
    .out_a_i    (out_a),
    .out_a_sel_o(out_a_sel),
    .reg_sel_o  (reg_sel),
    .scr_sel_o  (scr_sel),
    .data_o     (data),
    .index_o    (index),
    .valid_o    (valid),
    .ready_i    (ready),
    .last_o     (last),
    .busy_o     (busy),
    .done_o     (done)
  );

  assign out_a = rf[out_a_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver
  initial begin
    int stall;
    stall = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: begin ready = 1'b1; stall = 0; end
        1: begin ready = 1'($urandom); stall = 0; end
        2: begin
          if ((words_seen - stall_base) == 3 && valid && stall < 5) begin
            ready = 1'b0;
            stall++;
          end else begin
            ready = 1'b1;
          end
        end
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares accepted words and checks that stalled words hold.
  initial begin
    exp_t e;
    bit   hold;
    logic [15:0] h_data;
    logic [2:0]  h_idx;
    logic        h_last;
    hold = 0;
    h_data = '0; h_idx = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (done) done_cnt++;
        if (hold) begin
          chk("stall_data",  {16'h0, data},  {16'h0, h_data});
          chk("stall_index", {29'h0, index}, {29'h0, h_idx});
          chk("stall_last",  {31'h0, last},  {31'h0, h_last});
          chk("stall_valid", {31'h0, valid}, 32'h1);
        end
        if (valid && ready) begin
          words_seen++;
          if (q.size() == 0) begin
            chk("unexpected_word", {29'h0, index}, 32'hFFFFFFFF);
          end else begin
            e = q.pop_front();
            chk("word_index", {29'h0, index}, {29'h0, e.idx});
            chk("word_data",  {16'h0, data},  {16'h0, e.data});
            chk("word_last",  {31'h0, last},  {31'h0, e.last});
          end
        end
        hold   = valid && !ready;
        h_data = data;
        h_idx  = index;
        h_last = last;
      end
    end
  end

  // Queues the reference stream for mask m, pulses start, and waits for Done.
  task automatic run_dump(input logic [7:0] m, input bit poke, input bit chk_lat);
    exp_t loc[$];
    exp_t e;
    logic [15:0] x;
    int edges;
    int fv;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.idx = 3'(i); e.data = rf[i]; e.last = 1'b0;
        loc.push_back(e);
        x ^= rf[i];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    e.idx = 3'b111; e.data = x; e.last = 1'b0;
    loc.push_back(e);
`endif
    if (loc.size() > 0) begin
      e = loc[loc.size() - 1];
      e.last = 1'b1;
      loc[loc.size() - 1] = e;
    end
    foreach (loc[i]) q.push_back(loc[i]);

    start = 1'b1;
    mask  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = 8'($urandom);
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    edges = 1;
    fv    = -1;
    while (!done && edges < 2000) begin
      if (valid && fv < 0) fv = edges;
      if (poke && edges == 3) begin
        start = 1'b1;
        mask  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      // Random RF write data each cycle; it lands only if an enable is low.
      x = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (!reg_sel[i]) rf[i] = x;
        if (!scr_sel[i]) rf[i + 4] = x;
      end
      chk("rf_enables", {24'h0, reg_sel, scr_sel}, 32'hFF);
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    chk("done_seen", {31'h0, done}, 32'h1);
    if (chk_lat) begin
      chk("done_latency", edges, 1 + 2 * loc.size());
      if (loc.size() > 0) chk("first_valid_latency", fv, 2);
    end
    chk("valid_at_done", {31'h0, valid}, 32'h0);
    chk("busy_at_done",  {31'h0, busy},  32'h1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    logic [15:0] snap [8];
    int dc;
    int bound;
    rst_n = 1'b0;
    start = 1'b0;
    mask  = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",     {31'h0, valid}, 32'h0);
    chk("rst_busy",      {31'h0, busy},  32'h0);
    chk("rst_done",      {31'h0, done},  32'h0);
    chk("rst_last",      {31'h0, last},  32'h0);
    chk("rst_data",      {16'h0, data},  32'h0);
    chk("rst_index",     {29'h0, index}, 32'h0);
    chk("rst_out_a_sel", {29'h0, out_a_sel}, 32'h0);
    chk("rst_sel",       {24'h0, reg_sel, scr_sel}, 32'hFF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word dump with Ready high
    rf[0] = 16'h1234; rf[1] = 16'h5678;
    ready_mode = 0;
    run_dump(8'b0000_0011, 1'b0, 1'b1);

    // Single scratch register
    for (int i = 0; i < 8; i++) rf[i] = 16'h1234;
    rf[5] = 16'h3548;
    run_dump(8'b0010_0000, 1'b0, 1'b1);

    // Full dump with a 5-cycle stall on the fourth word
    for (int i = 0; i < 8; i++) begin
      rf[i]   = 16'($urandom);
      snap[i] = rf[i];
    end
    stall_base = words_seen;
    ready_mode = 2;
    run_dump(8'hFF, 1'b0, 1'b0);
    ready_mode = 0;
    for (int i = 0; i < 8; i++) chk("rf_frozen", {16'h0, rf[i]}, {16'h0, snap[i]});

    // Empty mask, then Start pokes while busy
    dc = words_seen;
    run_dump(8'h00, 1'b1, 1'b1);
`ifndef DUMP_CHECKSUM_EN
    chk("empty_no_words", words_seen - dc, 0);
`endif
    run_dump(8'b1010_0101, 1'b1, 1'b1);

    // Randomized dumps
    repeat (20) begin
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      ready_mode = int'($urandom_range(0, 1));
      run_dump(8'($urandom), 1'($urandom), ready_mode == 0);
    end
    ready_mode = 0;

    // Asynchronous reset in the middle of a stalled word
    ready_mode = 3;
    start = 1'b1;
    mask  = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    bound = 0;
    while (!valid && bound < 20) begin
      @(posedge clk);
      #1;
      bound++;
    end
    chk("reset_test_valid_reached", {31'h0, valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, valid}, 32'h0);
    chk("async_rst_busy",  {31'h0, busy},  32'h0);
    chk("async_rst_done",  {31'h0, done},  32'h0);
    chk("async_rst_sel",   {24'h0, reg_sel, scr_sel}, 32'hFF);
    q.delete();
    ready_mode = 0;
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stray_done", done_cnt, dc);
    chk("idle_after_rst", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
